// File: rtl/seg_disp_pkg.sv
// seg_disp_pkg: register map offsets, reset values and hex segment table for seg_disp_bus_ctrl
package seg_disp_pkg;
    localparam int OFF_DIGIT0 = 0;
    // the remaining offsets are relative to NUM_DIGITS
    localparam int OFF_CTRL   = 0;
    localparam int OFF_BLANK  = 1;
    localparam int OFF_BRIGHT = 2;
    localparam int OFF_STATUS = 3;
    localparam logic [4:0] DIGIT_RST  = 5'h00;
    localparam logic [1:0] CTRL_RST   = 2'b01;
    localparam logic [7:0] BLANK_RST  = 8'h00;
    localparam logic [2:0] BRIGHT_RST = 3'd7;
    localparam logic [6:0] HEX_SEG [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };
endpackage

// File: rtl/seg_hex_decoder.sv
// seg_hex_decoder: 4-bit hex value to active-high segments g..a
module seg_hex_decoder
    import seg_disp_pkg::*;
(
    input  logic [3:0] val,
    output logic [6:0] seg
);
    assign seg = HEX_SEG[val];
endmodule

// File: rtl/seg_disp_bus_ctrl.sv
// seg_disp_bus_ctrl: bus-mapped multiplexed seven-segment controller
// with blanking, decimal points, PWM brightness, blink and scan status.
module seg_disp_bus_ctrl
    import seg_disp_pkg::*;
#(
    parameter logic [7:0] BASE_ADDR   = 8'hD0,
    parameter int         NUM_DIGITS  = 4,
    parameter int         DIV_WIDTH   = 16,
    parameter int         BLINK_WIDTH = 6
) (
    input  logic                  CLK,
    input  logic                  RESET_N,
    inout  wire  [7:0]            BUS_DATA,
    input  logic [7:0]            BUS_ADDR,
    input  logic                  BUS_WE,
    output logic [NUM_DIGITS-1:0] SEG_SELECT,
    output logic [7:0]            DEC_OUT
);
    localparam logic [7:0] A_CTRL     = 8'(NUM_DIGITS + OFF_CTRL);
    localparam logic [7:0] A_BLANK    = 8'(NUM_DIGITS + OFF_BLANK);
    localparam logic [7:0] A_BRIGHT   = 8'(NUM_DIGITS + OFF_BRIGHT);
    localparam logic [7:0] A_STATUS   = 8'(NUM_DIGITS + OFF_STATUS);
    localparam logic [7:0] BLANK_MASK = 8'((1 << NUM_DIGITS) - 1);
    localparam logic [2:0] LAST_IDX   = 3'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] ONE_HOT0 = 1;

    logic [4:0]             digit [8];
    logic [1:0]             ctrl;
    logic [7:0]             blank;
    logic [2:0]             bright;
    logic [DIV_WIDTH-1:0]   presc;
    logic [2:0]             idx;
    logic [BLINK_WIDTH-1:0] frame;
    logic                   blink;
    logic                   rd_en;
    logic [7:0]             rd_data;
    logic [7:0]             rd_mux;
    logic [7:0]             off;
    logic                   in_range;
    logic                   dark;
    logic [4:0]             cur;
    logic [6:0]             seg;

    // offset arithmetic wraps mod 256, so addresses below BASE_ADDR fall out of range
    assign off      = BUS_ADDR - BASE_ADDR;
    assign in_range = off <= A_STATUS;
    assign cur      = digit[idx];
    assign dark     = !ctrl[0] || blank[idx] || presc[DIV_WIDTH-1 -: 3] > bright || (ctrl[1] && blink);
    assign BUS_DATA = rd_en ? rd_data : 8'bz;

    always_comb
        rd_mux = off < A_CTRL   ? {3'b000, digit[off[2:0]]} :
                 off == A_CTRL  ? {6'b0, ctrl} :
                 off == A_BLANK ? blank :
                 off == A_BRIGHT ? {5'b0, bright} :
                 {blink, 4'b0, idx};

    seg_hex_decoder u_dec (.val(cur[3:0]), .seg(seg));

    always_ff @(posedge CLK or negedge RESET_N)
        if (!RESET_N) begin
            for (int i = 0; i < 8; i++) digit[i] <= DIGIT_RST;
            ctrl       <= CTRL_RST;
            blank      <= BLANK_RST;
            bright     <= BRIGHT_RST;
            presc      <= '0;
            idx        <= '0;
            frame      <= '0;
            blink      <= 1'b0;
            rd_en      <= 1'b0;
            rd_data    <= '0;
            SEG_SELECT <= '1;
            DEC_OUT    <= 8'hFF;
        end else begin
            presc <= presc + 1'b1;
            if (&presc) begin
                idx <= idx == LAST_IDX ? 3'd0 : idx + 3'd1;
                if (idx == LAST_IDX) begin
                    frame <= frame + 1'b1;
                    if (&frame) blink <= ~blink;
                end
            end
            if (BUS_WE && in_range) begin
                if (off < A_CTRL) digit[off[2:0]] <= BUS_DATA[4:0];
                if (off == A_CTRL) ctrl <= BUS_DATA[1:0];
                if (off == A_BLANK) blank <= BUS_DATA & BLANK_MASK;
                if (off == A_BRIGHT) bright <= BUS_DATA[2:0];
            end
            rd_en      <= !BUS_WE && in_range;
            rd_data    <= rd_mux;
            SEG_SELECT <= dark ? '1 : ~(ONE_HOT0 << idx);
            DEC_OUT    <= dark ? 8'hFF : {~cur[4], ~seg};
        end
endmodule

// File: tb/tb_seg_disp_bus_ctrl.sv
// tb_seg_disp_bus_ctrl: directed bench for seg_disp_bus_ctrl with an arithmetic
// reference model compared every cycle plus literal spot checks.
module tb_seg_disp_bus_ctrl;
    localparam int N = 4, DW = 4, BW = 1;
    localparam logic [7:0] BASE = 8'hD0;

    logic clk = 0, rst_n = 0;
    logic [7:0] addr = 0, wdata = 0;
    logic we = 0, drv = 0;
    tri1 [7:0] bus;
    logic [N-1:0] sel;
    logic [7:0] dec;

    assign bus = drv ? wdata : 8'bz;

    seg_disp_bus_ctrl #(.BASE_ADDR(BASE), .NUM_DIGITS(N), .DIV_WIDTH(DW), .BLINK_WIDTH(BW)) dut (
        .CLK(clk), .RESET_N(rst_n), .BUS_DATA(bus), .BUS_ADDR(addr),
        .BUS_WE(we), .SEG_SELECT(sel), .DEC_OUT(dec)
    );

    always #5 clk = ~clk;

    int errors = 0, checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // model: scan position is pure arithmetic on the number of edges since reset
    logic [6:0] hexseg [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    logic [4:0] m_dig [N];
    logic [1:0] m_ctrl;
    logic [N-1:0] m_blank;
    logic [2:0] m_bright;
    int cyc;
    logic [N-1:0] e_sel = '1;
    logic [7:0] e_dec = 8'hFF, e_bus = 8'hFF;

    always @(posedge clk or negedge rst_n) begin
        int p, d, blk, ph, off;
        logic dark;
        if (!rst_n) begin
            cyc = 0; m_ctrl = 2'b01; m_bright = 3'd7; m_blank = '0;
            for (int i = 0; i < N; i++) m_dig[i] = 5'h0;
            e_sel = '1; e_dec = 8'hFF; e_bus = 8'hFF;
        end else begin
            p   = cyc % (1 << DW);
            d   = (cyc / (1 << DW)) % N;
            blk = (cyc / ((1 << DW) * N * (1 << BW))) % 2;
            ph  = p / (1 << (DW - 3));
            dark = m_ctrl[0] == 1'b0 || m_blank[d] == 1'b1 || ph > int'(m_bright) || (m_ctrl[1] && blk == 1);
            e_sel = '1;
            if (!dark) e_sel[d] = 1'b0;
            e_dec = dark ? 8'hFF : {~m_dig[d][4], ~hexseg[m_dig[d][3:0]]};
            off = int'(addr) - int'(BASE);
            e_bus = 8'hFF;
            if (off >= 0 && off < N + 4) begin
                if (!we) begin
                    if (off < N) e_bus = 8'(m_dig[off]);
                    else if (off == N) e_bus = 8'(m_ctrl);
                    else if (off == N + 1) e_bus = 8'(m_blank);
                    else if (off == N + 2) e_bus = 8'(m_bright);
                    else e_bus = {blk[0], 4'b0, d[2:0]};
                end else begin
                    if (off < N) m_dig[off] = bus[4:0];
                    else if (off == N) m_ctrl = bus[1:0];
                    else if (off == N + 1) m_blank = bus[N-1:0];
                    else if (off == N + 2) m_bright = bus[2:0];
                end
            end
            cyc++;
        end
    end

    always @(posedge clk) begin
        #1;
        chk("model_sel", sel, e_sel);
        chk("model_dec", dec, e_dec);
        if (!drv) chk("model_bus", bus, e_bus);
    end

    task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk); addr = a; we = 1; wdata = d; drv = 1;
        @(negedge clk); addr = 0; we = 0; drv = 0;
    endtask

    task automatic bus_read(input logic [7:0] a, output logic [7:0] d);
        @(negedge clk); addr = a; we = 0;
        @(posedge clk); #1 d = bus;
        @(negedge clk); addr = 0;
        @(posedge clk);
    endtask

    task automatic count_lit(input int n, output int c, output int s1);
        c = 0; s1 = 0;
        repeat (n) begin
            @(posedge clk); #1;
            if (sel != '1) c++;
            if (sel == 4'b1101) s1++;
        end
    endtask

    task automatic wait_sel(input logic [N-1:0] t, input string name);
        int k = 0;
        while (k < 200) begin
            @(posedge clk); #1;
            if (sel == t) break;
            k++;
        end
        if (k == 200) chk({name, "_timeout"}, 0, 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] r, r2;
        int c, s1, len;
        repeat (3) @(negedge clk);
        chk("rst_sel", sel, 4'hF);
        chk("rst_dec", dec, 8'hFF);
        chk("rst_bus", bus, 8'hFF);
        rst_n = 1;
        bus_read(BASE + 4, r); chk("rd_ctrl_rst", r, 8'h01);
        bus_read(BASE + 6, r); chk("rd_bright_rst", r, 8'h07);

        bus_write(BASE + 0, 8'h13);
        bus_write(BASE + 1, 8'h0A);
        wait_sel(4'b1110, "slot0");
        chk("slot0_dec", dec, 8'h30);
        wait_sel(4'b1101, "slot1");
        chk("slot1_dec", dec, 8'h88);
        len = 0;
        while (sel == 4'b1101 && len < 100) begin
            len++;
            @(posedge clk); #1;
        end
        chk("slot_len", len, 16);
        chk("slot2_dec", dec, 8'hC0);
        chk("slot2_sel", sel, 4'b1011);

        bus_write(BASE + 5, 8'h02);
        bus_write(BASE + 6, 8'h01);
        count_lit(64, c, s1);
        chk("pwm_lit", c, 12);
        chk("blank_slot1", s1, 0);

        bus_write(BASE + 4, 8'h03);
        count_lit(256, c, s1);
        chk("blink_lit", c, 24);
        bus_read(BASE + 7, r);
        repeat (126) @(posedge clk);
        bus_read(BASE + 7, r2);
        chk("blink_toggle", r[7] ^ r2[7], 1);

        bus_write(BASE + 4, 8'h00);
        count_lit(64, c, s1);
        chk("disabled_lit", c, 0);
        bus_read(BASE + 7, r);
        repeat (14) @(posedge clk);
        bus_read(BASE + 7, r2);
        chk("idx_advance", r2[2:0], 3'((r[2:0] + 1) % N));

        bus_read(BASE + 8, r); chk("rd_out_of_range", r, 8'hFF);
        bus_write(BASE + 7, 8'h55);
        bus_read(BASE + 7, r); chk("status_wr_dropped", r == 8'h55, 0);
        bus_write(BASE + 0, 8'hFF);
        bus_read(BASE + 0, r); chk("rd_d0_masked", r, 8'h1F);
        bus_write(BASE + 5, 8'hF0);
        bus_read(BASE + 5, r); chk("rd_blank_masked", r, 8'h00);
        @(posedge clk); #1 chk("bus_idle", bus, 8'hFF);

        @(negedge clk); addr = BASE + 0; we = 0;
        @(posedge clk); #1 chk("rd_before_rst", bus, 8'h1F);
        #2 rst_n = 0;
        #1;
        chk("async_rst_bus", bus, 8'hFF);
        chk("async_rst_sel", sel, 4'hF);
        chk("async_rst_dec", dec, 8'hFF);
        addr = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
        bus_read(BASE + 4, r); chk("rst2_ctrl", r, 8'h01);
        bus_read(BASE + 6, r); chk("rst2_bright", r, 8'h07);
        bus_read(BASE + 0, r); chk("rst2_d0", r, 8'h00);
        bus_read(BASE + 5, r); chk("rst2_blank", r, 8'h00);
        repeat (2) @(posedge clk);
        #2;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
